// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  localparam word_t PC_INC = 32'd1;
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: memory request/response and fetch-buffer signals of the fetch unit
interface inst_fetch_if;
  import fetch_pkg::*;
  word_t mem_addr;
  word_t mem_dout;
  word_t br_target;
  word_t inst;
  word_t inst_pc;
  logic mem_ren;
  logic mem_ack;
  logic mem_stall;
  logic if_en;
  logic br_en;
  logic inst_valid;
  logic fetch_err;
  modport master (
    output mem_addr, mem_ren, inst, inst_pc, inst_valid, fetch_err,
    input mem_dout, mem_ack, mem_stall, if_en, br_en, br_target
  );
  modport slave (
    input mem_addr, mem_ren, inst, inst_pc, inst_valid, fetch_err,
    output mem_dout, mem_ack, mem_stall, if_en, br_en, br_target
  );
endinterface

// File: rtl/fetch_timeout.sv
// fetch_timeout: counts consecutive unacknowledged request cycles and flags expiry
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = run_i & ~clr_i & (cnt_q == LAST);
  assign cnt_d = (~run_i | clr_i) ? '0 : cnt_q + 1'b1;
  // cycle counter, held at zero outside the request state
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding-read instruction fetcher with one-entry buffer;
// optional request timeout enabled by defining INST_FETCH_TIMEOUT_EN
module inst_fetch
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic clk,
  input logic rst,
  inst_fetch_if.master bus
);
  state_e state_q;
  word_t pc_q, addr_q, inst_q, inst_pc_q;
  logic valid_q, kill_q, err_q, timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef INST_FETCH_TIMEOUT_EN
  fetch_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .run_i(state_q == S_REQ),
    .clr_i(bus.mem_ack),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  assign bus.mem_ren = (state_q == S_REQ) & ~bus.mem_ack & ~rst;
  assign bus.mem_addr = (state_q == S_REQ) ? addr_q : pc_q;
  assign bus.inst = inst_q;
  assign bus.inst_pc = inst_pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.fetch_err = err_q;
  // request FSM with fetch buffer; a redirect is applied last so it overrides consume and ack data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      inst_q <= '0;
      inst_pc_q <= '0;
      valid_q <= 1'b0;
      kill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (valid_q & bus.if_en) valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (~bus.br_en & ~err_q & (~valid_q | bus.if_en)) begin
          state_q <= S_REQ;
          addr_q <= pc_q;
        end
      end else if (timeout) begin
        state_q <= S_IDLE;
        err_q <= 1'b1;
        kill_q <= 1'b0;
      end else if (bus.mem_ack) begin
        state_q <= S_IDLE;
        kill_q <= 1'b0;
        if (~kill_q & ~bus.br_en) begin
          inst_q <= bus.mem_dout;
          inst_pc_q <= addr_q;
          valid_q <= 1'b1;
          pc_q <= pc_q + PC_INC;
        end
      end else if (bus.br_en) kill_q <= 1'b1;
      if (bus.br_en) begin
        pc_q <= bus.br_target;
        valid_q <= 1'b0;
      end
    end
  end
endmodule
